// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential byte fetches and buffers the returned bytes in a
// small FIFO for pipe_stage0. Supports flush/redirect and a shared memory bus (memGrant).
module fetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        memGrant,
  input  logic [7:0]  MemDataIn,
  input  logic        flush,
  input  logic [15:0] flushAddr,
  input  logic        ready,
  output logic        memReq,
  output logic [15:0] AddrOut,
  output logic [7:0]  PipeOut,
  output logic        valid,
  output logic [3:0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StReset, StFetch, StFlush} state_e;

  state_e          state_q;
  logic [15:0]     addr_q;
  logic            inflight_q;
  logic [3:0]      count_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [7:0]      mem_q [DEPTH];

  logic       push;
  logic       pop;
  logic       accept;
  logic [4:0] occupancy;

  always_comb begin
    // Reserve a slot for every outstanding request so a returning byte always fits.
    occupancy = {1'b0, count_q} + {4'b0000, inflight_q} + 5'd1;
    memReq    = (state_q == StFetch) && (occupancy <= 5'(DEPTH));
    accept    = memReq && memGrant;
    valid     = (count_q != 4'd0);
    PipeOut   = valid ? mem_q[rd_ptr_q] : 8'h00;
    pop       = valid && ready;
    push      = inflight_q;
  end

  assign AddrOut = addr_q;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q    <= StReset;
      addr_q     <= RESET_ADDR;
      inflight_q <= 1'b0;
      count_q    <= 4'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      unique case (state_q)
        StReset: state_q <= StFetch;
        StFetch: begin
          if (flush) begin
            // Dropping inflight_q discards any byte still on its way back.
            state_q    <= StFlush;
            addr_q     <= flushAddr;
            inflight_q <= 1'b0;
            count_q    <= 4'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
          end else begin
            inflight_q <= accept;
            if (accept) addr_q <= addr_q + 16'd1;
            if (push) begin
              mem_q[wr_ptr_q] <= MemDataIn;
              wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + {3'b000, push} - {3'b000, pop};
          end
        end
        StFlush: begin
          if (flush) addr_q <= flushAddr;
          else       state_q <= StFetch;
        end
        default: state_q <= StReset;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, then randomized traffic checked
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [15:0] RESET_ADDR = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        memGrant = 1'b0;
  logic [7:0]  MemDataIn = 8'h00;
  logic        flush = 1'b0;
  logic [15:0] flushAddr = 16'h0000;
  logic        ready = 1'b0;
  logic        memReq;
  logic [15:0] AddrOut;
  logic [7:0]  PipeOut;
  logic        valid;
  logic [3:0]  count;

  int passed = 0;
  int total  = 0;

  fetch_queue #(
    .DEPTH     (DEPTH),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .memGrant (memGrant),
    .MemDataIn(MemDataIn),
    .flush    (flush),
    .flushAddr(flushAddr),
    .ready    (ready),
    .memReq   (memReq),
    .AddrOut  (AddrOut),
    .PipeOut  (PipeOut),
    .valid    (valid),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue, one outstanding request, mode 0=reset 1=fetching 2=flushing.
  logic [7:0]  m_q[$];
  bit          m_infl = 1'b0;
  logic [15:0] m_infl_addr = 16'h0000;
  logic [15:0] m_addr = RESET_ADDR;
  int          m_mode = 0;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return 8'hA0 + a[7:0];
  endfunction

  function automatic bit model_req();
    return (m_mode == 1) && (m_q.size() + int'(m_infl) + 1 <= DEPTH);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic model_update();
    bit req;
    bit do_pop;
    req = model_req();
    if (reset_in) begin
      m_q.delete();
      m_infl = 1'b0;
      m_addr = RESET_ADDR;
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (flush) begin
        m_q.delete();
        m_infl = 1'b0;
        m_addr = flushAddr;
        m_mode = 2;
      end else begin
        do_pop = (m_q.size() > 0) && ready;
        if (do_pop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(mem_byte(m_infl_addr));
        m_infl = req && memGrant;
        if (m_infl) begin
          m_infl_addr = m_addr;
          m_addr      = m_addr + 16'd1;
        end
      end
    end else begin
      if (flush) m_addr = flushAddr;
      else       m_mode = 1;
    end
  endtask

  task automatic drive(input bit r, input bit g, input bit f, input logic [15:0] fa,
                       input bit rd);
    @(negedge clk);
    reset_in  = r;
    memGrant  = g;
    flush     = f;
    flushAddr = fa;
    ready     = rd;
    #1;
  endtask

  // Memory stub answers an accepted request one cycle later; junk otherwise.
  task automatic edge_step();
    bit          acc;
    logic [15:0] a;
    acc = memReq && memGrant;
    a   = AddrOut;
    model_update();
    @(posedge clk);
    #1;
    MemDataIn = acc ? mem_byte(a) : 8'($urandom);
  endtask

  task automatic model_check(input int cyc);
    bit req;
    req = model_req();
    check($sformatf("rand%0d count", cyc), count, m_q.size());
    check($sformatf("rand%0d valid", cyc), valid, (m_q.size() > 0));
    check($sformatf("rand%0d PipeOut", cyc), PipeOut, (m_q.size() > 0) ? m_q[0] : 8'h00);
    check($sformatf("rand%0d memReq", cyc), memReq, req);
    if (req) check($sformatf("rand%0d AddrOut", cyc), AddrOut, m_addr);
  endtask

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          fl;
    logic [15:0] fa;
    bit          rdy;
    bit          req;
    logic [15:0] addr;
    int          cnt;
    bit          vld;
    logic [7:0]  pipe;
  } vec_t;

  vec_t vt[29];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int rdy_pct;
    bit r;
    bit f;
    logic [15:0] fa;
    // rst gnt fl fa rdy | req addr cnt vld pipe
    vt[0]  = '{1, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00};
    vt[1]  = '{0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00};
    vt[2]  = '{0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 8'h00};
    vt[3]  = '{0, 1, 0, 16'h0000, 0, 1, 16'h0001, 0, 0, 8'h00};
    vt[4]  = '{0, 1, 0, 16'h0000, 0, 1, 16'h0002, 1, 1, 8'hA0};
    vt[5]  = '{0, 1, 0, 16'h0000, 0, 1, 16'h0003, 2, 1, 8'hA0};
    vt[6]  = '{0, 1, 0, 16'h0000, 0, 0, 16'h0000, 3, 1, 8'hA0};
    vt[7]  = '{0, 1, 0, 16'h0000, 1, 0, 16'h0000, 4, 1, 8'hA0};
    vt[8]  = '{0, 1, 0, 16'h0000, 0, 1, 16'h0004, 3, 1, 8'hA1};
    vt[9]  = '{0, 1, 0, 16'h0000, 1, 0, 16'h0000, 3, 1, 8'hA1};
    vt[10] = '{0, 1, 0, 16'h0000, 1, 1, 16'h0005, 3, 1, 8'hA2};
    vt[11] = '{0, 1, 1, 16'h1234, 0, 1, 16'h0006, 2, 1, 8'hA3};
    vt[12] = '{0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00};
    vt[13] = '{0, 1, 0, 16'h0000, 0, 1, 16'h1234, 0, 0, 8'h00};
    vt[14] = '{0, 1, 0, 16'h0000, 0, 1, 16'h1235, 0, 0, 8'h00};
    vt[15] = '{0, 1, 1, 16'hFFFE, 0, 1, 16'h1236, 1, 1, 8'hD4};
    vt[16] = '{0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00};
    vt[17] = '{0, 1, 0, 16'h0000, 0, 1, 16'hFFFE, 0, 0, 8'h00};
    vt[18] = '{0, 1, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 0, 8'h00};
    vt[19] = '{0, 1, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 8'h9E};
    vt[20] = '{0, 0, 0, 16'h0000, 0, 1, 16'h0001, 2, 1, 8'h9E};
    vt[21] = '{0, 0, 0, 16'h0000, 0, 1, 16'h0001, 3, 1, 8'h9E};
    vt[22] = '{0, 0, 0, 16'h0000, 0, 1, 16'h0001, 3, 1, 8'h9E};
    vt[23] = '{0, 1, 0, 16'h0000, 1, 1, 16'h0001, 3, 1, 8'h9E};
    vt[24] = '{0, 1, 0, 16'h0000, 1, 1, 16'h0002, 2, 1, 8'h9F};
    vt[25] = '{0, 1, 0, 16'h0000, 0, 1, 16'h0003, 2, 1, 8'hA0};
    vt[26] = '{1, 1, 0, 16'h0000, 0, 0, 16'h0000, 3, 1, 8'hA0};
    vt[27] = '{0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 8'h00};
    vt[28] = '{0, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 8'h00};

    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    edge_step();

    for (int i = 0; i < 29; i++) begin
      drive(vt[i].rst, vt[i].gnt, vt[i].fl, vt[i].fa, vt[i].rdy);
      check($sformatf("vec%0d count", i), count, vt[i].cnt);
      check($sformatf("vec%0d valid", i), valid, vt[i].vld);
      check($sformatf("vec%0d PipeOut", i), PipeOut, vt[i].pipe);
      check($sformatf("vec%0d memReq", i), memReq, vt[i].req);
      if (vt[i].req) check($sformatf("vec%0d AddrOut", i), AddrOut, vt[i].addr);
      edge_step();
    end

    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) rdy_pct = (c / 500) % 3 == 0 ? 10 : ((c / 500) % 3 == 1 ? 90 : 50);
      r  = ($urandom_range(0, 99) == 0);
      f  = (m_mode != 0) && ($urandom_range(0, 15) == 0);
      fa = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                       : 16'($urandom);
      drive(r, ($urandom_range(0, 3) != 0), f, fa, ($urandom_range(0, 99) < rdy_pct));
      model_check(c);
      edge_step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
